// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_arbiter
//  Purpose  : Shares a single ALU between N_REQ requesters. Requests are
//             granted round-robin. The granted operands are latched, a
//             one-cycle start is issued, and the block waits for the ALU
//             result (bounded by a watchdog). The result is returned only
//             to the granted requester.
//  Ports    : clk/rst              - clock, synchronous active-high reset
//             req_valid/op/a/b/signed - packed per-requester request bus
//             req_ready            - one-hot accept pulse
//             resp_valid           - one-hot response pulse
//             resp_data/error/timeout - response payload (held until next)
//             alu_start/op/a/b/rs*_signed - ALU command side (registered)
//             alu_busy/valid/error/result - ALU status/result side
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [5*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    input  logic [2*N_REQ-1:0]     req_signed,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_error,
    output logic                   resp_timeout,
    output logic                   alu_start,
    output logic [4:0]             alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic                   alu_rs1_signed,
    output logic                   alu_rs2_signed,
    input  logic                   alu_busy,
    input  logic                   alu_valid,
    input  logic                   alu_error,
    input  logic [WIDTH-1:0]       alu_result
);

    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CW  = $clog2(TIMEOUT);
    localparam logic [c_CW-1:0]  c_CNT_LAST  = c_CW'(TIMEOUT - 1);
    localparam logic [c_IDW-1:0] c_LAST_INIT = c_IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_IDW-1:0]   r_grant;
    logic [c_IDW-1:0]   r_last_grant;
    logic [c_CW-1:0]    r_cnt;

    logic               w_any;
    logic               w_found_hi;
    logic [c_IDW-1:0]   w_pick_hi;
    logic [c_IDW-1:0]   w_pick_lo;
    logic [c_IDW-1:0]   w_pick;
    logic [4:0]         w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [1:0]         w_sg;

    // Round-robin pick: the lowest pending index above last_grant wins;
    // if none exists, wrap and take the lowest pending index overall.
    // Scanning downward lets the lowest index overwrite higher ones.
    always_comb begin
        w_any      = |req_valid;
        w_found_hi = 1'b0;
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(r_last_grant)) begin
                    w_found_hi = 1'b1;
                    w_pick_hi  = c_IDW'(i);
                end else begin
                    w_pick_lo  = c_IDW'(i);
                end
            end
        end
        w_pick = w_found_hi ? w_pick_hi : w_pick_lo;

        // Operand mux for the picked requester
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        w_sg = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == c_IDW'(i)) begin
                w_op = req_op[5*i +: 5];
                w_a  = req_a[WIDTH*i +: WIDTH];
                w_b  = req_b[WIDTH*i +: WIDTH];
                w_sg = req_signed[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_last_grant   <= c_LAST_INIT;
            r_cnt          <= '0;
            req_ready      <= '0;
            resp_valid     <= '0;
            resp_data      <= '0;
            resp_error     <= 1'b0;
            resp_timeout   <= 1'b0;
            alu_start      <= 1'b0;
            alu_op         <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_rs1_signed <= 1'b0;
            alu_rs2_signed <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            req_ready  <= '0;
            resp_valid <= '0;
            alu_start  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant        <= w_pick;
                        alu_op         <= w_op;
                        alu_a          <= w_a;
                        alu_b          <= w_b;
                        alu_rs1_signed <= w_sg[0];
                        alu_rs2_signed <= w_sg[1];
                        req_ready      <= c_ONE << w_pick;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Busy stall is not charged against the watchdog
                    if (!alu_busy) begin
                        alu_start <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A valid in the final watchdog cycle still wins
                    if (alu_valid) begin
                        resp_data    <= alu_result;
                        resp_error   <= alu_error;
                        resp_timeout <= 1'b0;
                        resp_valid   <= c_ONE << r_grant;
                        r_state      <= S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        resp_data    <= '0;
                        resp_error   <= 1'b1;
                        resp_timeout <= 1'b1;
                        resp_valid   <= c_ONE << r_grant;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_RESP: begin
                    // resp_valid is visible during this state
                    r_last_grant <= r_grant;
                    r_cnt        <= '0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
